// File: rtl/regfile_writeback_arbiter.sv
// Single write-port arbiter for the register file: pipeline writebacks win, divider
// results are buffered in a small FIFO, and a busy scoreboard tracks pending long results.
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbValid,
  input  logic [ADDR_WIDTH-1:0] wbRd,
  input  logic [DATA_WIDTH-1:0] wbData,
  input  logic                  divValid,
  input  logic [ADDR_WIDTH-1:0] divRd,
  input  logic [DATA_WIDTH-1:0] divData,
  output logic                  divReady,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRd,
  output logic [31:0]           busyMask,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_BYPASS
  } src_t;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  from_div;

  src_t                  src;
  logic                  push;
  logic                  pop;
  logic                  wb_sel;
  logic                  div_keep;
  logic [31:0]           set_mask;
  logic [31:0]           clear_mask;
  logic [31:0]           busy_next;

  assign divReady  = (count < CNT_W'(FIFO_DEPTH));
  assign fifoCount = count;

  // Results for x0 are swallowed here so they never occupy a FIFO slot or the port.
  always_comb begin
    src      = SRC_NONE;
    push     = 1'b0;
    pop      = 1'b0;
    wb_sel   = wbValid && (wbRd != '0);
    div_keep = divValid && divReady && (divRd != '0);
    if (wb_sel) begin
      src  = SRC_WB;
      push = div_keep;
    end else if (count != '0) begin
      src  = SRC_FIFO;
      pop  = 1'b1;
      push = div_keep;
    end else if (div_keep) begin
      src = SRC_BYPASS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      from_div  <= 1'b0;
    end else begin
      case (src)
        SRC_WB: begin
          regWrite  <= 1'b1;
          writeReg  <= wbRd;
          writeData <= wbData;
          from_div  <= 1'b0;
        end
        SRC_FIFO: begin
          regWrite  <= 1'b1;
          writeReg  <= fifo_rd[rd_ptr];
          writeData <= fifo_data[rd_ptr];
          from_div  <= 1'b1;
        end
        SRC_BYPASS: begin
          regWrite  <= 1'b1;
          writeReg  <= divRd;
          writeData <= divData;
          from_div  <= 1'b1;
        end
        default: begin
          regWrite <= 1'b0;
          from_div <= 1'b0;
        end
      endcase
    end
  end

  // Pointer width equals log2(depth), so the increments wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= divData;
      fifo_rd[wr_ptr]   <= divRd;
    end
  end

  // A new issue to the same register outranks the clear of the one just retiring.
  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (issueValid && (issueRd != '0)) set_mask = 32'd1 << issueRd;
    if (regWrite && from_div)          clear_mask = 32'd1 << writeReg;
    busy_next  = ((busyMask & ~clear_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busyMask <= '0;
    else     busyMask <= busy_next;
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: each task drives one scenario
// and compares the registered outputs against hand-computed values.
module tb_regfile_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        divValid;
  logic [4:0]  divRd;
  logic [31:0] divData;
  logic        divReady;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic [31:0] busyMask;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [2:0]  fifoCount;

  int checks = 0;
  int errors = 0;

  regfile_writeback_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wbValid    (wbValid),
    .wbRd       (wbRd),
    .wbData     (wbData),
    .divValid   (divValid),
    .divRd      (divRd),
    .divData    (divData),
    .divReady   (divReady),
    .issueValid (issueValid),
    .issueRd    (issueRd),
    .busyMask   (busyMask),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .fifoCount  (fifoCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wbValid    = 1'b0;
    wbRd       = '0;
    wbData     = '0;
    divValid   = 1'b0;
    divRd      = '0;
    divData    = '0;
    issueValid = 1'b0;
    issueRd    = '0;
  endtask

  task automatic test_reset();
    issueValid = 1'b1; issueRd = 5'd9;
    wbValid = 1'b1; wbRd = 5'd5; wbData = 32'h55;
    tick();
    drive_idle();
    checks++;
    if ({regWrite, busyMask} !== {1'b1, 32'h200}) begin
      errors++;
      $display("[TB] FAIL reset_pre got regWrite=%0b busy=%h want 1 00000200", regWrite, busyMask);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({regWrite, writeReg, writeData} !== {1'b0, 5'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL reset_out got %0b %0d %h want 0 0 0", regWrite, writeReg, writeData);
    end
    checks++;
    if ({divReady, fifoCount, busyMask} !== {1'b1, 3'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state got ready=%0b cnt=%0d busy=%h want 1 0 0", divReady, fifoCount, busyMask);
    end
    #2 rst = 1'b0;
    tick();
    checks++;
    if (regWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle got regWrite=%0b want 0", regWrite);
    end
  endtask

  task automatic test_pipeline();
    wbValid = 1'b1; wbRd = 5'd5; wbData = 32'hDEADBEEF;
    tick();
    checks++;
    if ({regWrite, writeReg, writeData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL pipe_write got %0b %0d %h want 1 5 deadbeef", regWrite, writeReg, writeData);
    end
    wbRd = 5'd0; wbData = 32'h1234;
    tick();
    drive_idle();
    checks++;
    if ({regWrite, writeReg, writeData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL pipe_rd0 got %0b %0d %h want 0 5 deadbeef", regWrite, writeReg, writeData);
    end
  endtask

  task automatic test_bypass();
    issueValid = 1'b1; issueRd = 5'd7;
    tick();
    drive_idle();
    checks++;
    if (busyMask !== 32'h80) begin
      errors++;
      $display("[TB] FAIL byp_set got %h want 00000080", busyMask);
    end
    divValid = 1'b1; divRd = 5'd7; divData = 32'h10;
    checks++;
    if (divReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byp_ready got %0b want 1", divReady);
    end
    tick();
    drive_idle();
    checks++;
    if ({regWrite, writeReg, writeData, busyMask} !== {1'b1, 5'd7, 32'h10, 32'h80}) begin
      errors++;
      $display("[TB] FAIL byp_write got %0b %0d %h busy=%h want 1 7 10 00000080", regWrite, writeReg, writeData, busyMask);
    end
    tick();
    checks++;
    if ({regWrite, busyMask} !== {1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL byp_clear got regWrite=%0b busy=%h want 0 0", regWrite, busyMask);
    end
  endtask

  task automatic test_contention();
    int held_rd;
    int exp_cnt;
    int exp_drain [5] = '{3, 3, 2, 1, 0};
    for (int i = 1; i <= 5; i++) begin
      issueValid = 1'b1; issueRd = 5'(i);
      tick();
    end
    drive_idle();
    checks++;
    if (busyMask !== 32'h3E) begin
      errors++;
      $display("[TB] FAIL cont_busy got %h want 0000003e", busyMask);
    end
    held_rd = 1;
    for (int i = 0; i < 6; i++) begin
      wbValid = 1'b1; wbRd = 5'(10 + i); wbData = 32'h100 + i;
      divValid = 1'b1; divRd = 5'(held_rd); divData = 32'hD0 + held_rd;
      tick();
      if (i < 4) held_rd++;
      exp_cnt = (i < 4) ? i + 1 : 4;
      checks++;
      if ({regWrite, writeReg, writeData} !== {1'b1, 5'(10 + i), 32'h100 + i}) begin
        errors++;
        $display("[TB] FAIL cont_wb[%0d] got %0b %0d %h want 1 %0d %h", i, regWrite, writeReg, writeData, 10 + i, 32'h100 + i);
      end
      checks++;
      if ({fifoCount, divReady} !== {3'(exp_cnt), exp_cnt < 4}) begin
        errors++;
        $display("[TB] FAIL cont_cnt[%0d] got cnt=%0d ready=%0b want %0d %0b", i, fifoCount, divReady, exp_cnt, exp_cnt < 4);
      end
    end
    wbValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      divValid = (k < 2); divRd = 5'd5; divData = 32'hD5;
      if (k < 2) begin
        checks++;
        if (divReady !== (k == 1)) begin
          errors++;
          $display("[TB] FAIL drain_ready[%0d] got %0b want %0b", k, divReady, k == 1);
        end
      end
      tick();
      checks++;
      if ({regWrite, writeReg, writeData, fifoCount} !== {1'b1, 5'(k + 1), 32'hD0 + k + 1, 3'(exp_drain[k])}) begin
        errors++;
        $display("[TB] FAIL drain[%0d] got %0b %0d %h cnt=%0d want 1 %0d %h %0d", k, regWrite, writeReg, writeData, fifoCount, k + 1, 32'hD0 + k + 1, exp_drain[k]);
      end
    end
    drive_idle();
    checks++;
    if (busyMask !== 32'h20) begin
      errors++;
      $display("[TB] FAIL drain_busy got %h want 00000020", busyMask);
    end
    tick();
    checks++;
    if ({regWrite, busyMask} !== {1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL drain_end got regWrite=%0b busy=%h want 0 0", regWrite, busyMask);
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 2; i++) begin
      wbValid = 1'b1; wbRd = 5'(30 + i); wbData = 32'h300 + i;
      divValid = 1'b1; divRd = 5'(20 + i); divData = 32'h2000 + i;
      tick();
    end
    checks++;
    if (fifoCount !== 3'd2) begin
      errors++;
      $display("[TB] FAIL pp_fill got %0d want 2", fifoCount);
    end
    wbValid = 1'b0; divRd = 5'd22; divData = 32'h2002;
    tick();
    divValid = 1'b0;
    checks++;
    if ({regWrite, writeReg, writeData, fifoCount} !== {1'b1, 5'd20, 32'h2000, 3'd2}) begin
      errors++;
      $display("[TB] FAIL pp_both got %0b %0d %h cnt=%0d want 1 20 2000 2", regWrite, writeReg, writeData, fifoCount);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({regWrite, writeReg, writeData, fifoCount} !== {1'b1, 5'(20 + k), 32'h2000 + k, 3'(2 - k)}) begin
        errors++;
        $display("[TB] FAIL pp_drain[%0d] got %0b %0d %h cnt=%0d want 1 %0d %h %0d", k, regWrite, writeReg, writeData, fifoCount, 20 + k, 32'h2000 + k, 2 - k);
      end
    end
    drive_idle();
  endtask

  task automatic test_wrap();
    int n;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 4; j++) begin
        n = b * 4 + j;
        wbValid = 1'b1; wbRd = 5'd31; wbData = 32'hFFFF;
        divValid = 1'b1; divRd = 5'(n + 1); divData = 32'hA5A50000 + n * 32'h111;
        tick();
      end
      drive_idle();
      checks++;
      if ({fifoCount, divReady} !== {3'd4, 1'b0}) begin
        errors++;
        $display("[TB] FAIL wrap_full[%0d] got cnt=%0d ready=%0b want 4 0", b, fifoCount, divReady);
      end
      for (int j = 0; j < 4; j++) begin
        n = b * 4 + j;
        tick();
        checks++;
        if ({regWrite, writeReg, writeData} !== {1'b1, 5'(n + 1), 32'hA5A50000 + n * 32'h111}) begin
          errors++;
          $display("[TB] FAIL wrap[%0d] got %0b %0d %h want 1 %0d %h", n, regWrite, writeReg, writeData, n + 1, 32'hA5A50000 + n * 32'h111);
        end
      end
    end
  endtask

  task automatic test_rd_zero();
    divValid = 1'b1; divRd = 5'd0; divData = 32'h77;
    issueValid = 1'b1; issueRd = 5'd0;
    tick();
    checks++;
    if ({regWrite, fifoCount, busyMask} !== {1'b0, 3'd0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rd0_div got regWrite=%0b cnt=%0d busy=%h want 0 0 0", regWrite, fifoCount, busyMask);
    end
    issueValid = 1'b0;
    wbValid = 1'b1; wbRd = 5'd3; wbData = 32'h333;
    tick();
    drive_idle();
    checks++;
    if ({regWrite, writeReg, writeData, fifoCount} !== {1'b1, 5'd3, 32'h333, 3'd0}) begin
      errors++;
      $display("[TB] FAIL rd0_push got %0b %0d %h cnt=%0d want 1 3 333 0", regWrite, writeReg, writeData, fifoCount);
    end
    tick();
  endtask

  task automatic test_set_wins();
    issueValid = 1'b1; issueRd = 5'd8;
    tick();
    drive_idle();
    divValid = 1'b1; divRd = 5'd8; divData = 32'h88;
    tick();
    drive_idle();
    checks++;
    if ({regWrite, writeReg, writeData} !== {1'b1, 5'd8, 32'h88}) begin
      errors++;
      $display("[TB] FAIL sw_byp got %0b %0d %h want 1 8 88", regWrite, writeReg, writeData);
    end
    issueValid = 1'b1; issueRd = 5'd8;
    tick();
    drive_idle();
    checks++;
    if (busyMask !== 32'h100) begin
      errors++;
      $display("[TB] FAIL sw_setwins got %h want 00000100", busyMask);
    end
    divValid = 1'b1; divRd = 5'd8; divData = 32'h89;
    tick();
    drive_idle();
    tick();
    checks++;
    if (busyMask !== 32'h0) begin
      errors++;
      $display("[TB] FAIL sw_clear got %h want 0", busyMask);
    end
  endtask

  task automatic test_reset_mid();
    int rds [3] = '{3, 4, 6};
    for (int i = 0; i < 3; i++) begin
      issueValid = 1'b1; issueRd = 5'(rds[i]);
      tick();
    end
    issueValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbValid = 1'b1; wbRd = 5'd12; wbData = 32'hC0 + i;
      divValid = 1'b1; divRd = 5'(rds[i]); divData = 32'h3333 + i;
      tick();
    end
    drive_idle();
    checks++;
    if ({fifoCount, busyMask} !== {3'd3, 32'h58}) begin
      errors++;
      $display("[TB] FAIL rm_pre got cnt=%0d busy=%h want 3 00000058", fifoCount, busyMask);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({regWrite, writeReg, writeData, fifoCount, busyMask, divReady} !== {1'b0, 5'd0, 32'd0, 3'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rm_reset got %0b %0d %h cnt=%0d busy=%h ready=%0b want 0 0 0 0 0 1", regWrite, writeReg, writeData, fifoCount, busyMask, divReady);
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({regWrite, fifoCount} !== {1'b0, 3'd0}) begin
        errors++;
        $display("[TB] FAIL rm_stale[%0d] got regWrite=%0b cnt=%0d want 0 0", k, regWrite, fifoCount);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    drive_idle();
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_pipeline();
    test_bypass();
    test_contention();
    test_push_pop();
    test_wrap();
    test_rd_zero();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
